// File: rtl/axi_mem_mux.sv
`default_nettype none
//============================================================================
// Module      : axi_mem_mux
// Description : N-host to 1-device AXI4 multiplexer for a shared DDR port.
//               Round-robin AR/AW arbitration into registered output stages,
//               host index prepended to device IDs, W beats steered by an
//               AW-order FIFO, R/B responses routed back by ID prefix.
// Revision    : 1.0 - initial release
//============================================================================
module axi_mem_mux #(
    parameter int NUM_HOSTS   = 2,
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 27,
    parameter int ID_WIDTH    = 8,
    parameter int WFIFO_DEPTH = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int HOST_IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1,
    localparam int DEV_ID_W   = ID_WIDTH + HOST_IDX_W
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    // host AR
    input  logic [NUM_HOSTS-1:0]             host_ar_valid,
    output logic [NUM_HOSTS-1:0]             host_ar_ready,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0]  host_ar_addr,
    input  logic [NUM_HOSTS*ID_WIDTH-1:0]    host_ar_id,
    input  logic [NUM_HOSTS*8-1:0]           host_ar_len,
    input  logic [NUM_HOSTS*3-1:0]           host_ar_size,
    input  logic [NUM_HOSTS*2-1:0]           host_ar_burst,
    // host AW
    input  logic [NUM_HOSTS-1:0]             host_aw_valid,
    output logic [NUM_HOSTS-1:0]             host_aw_ready,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0]  host_aw_addr,
    input  logic [NUM_HOSTS*ID_WIDTH-1:0]    host_aw_id,
    input  logic [NUM_HOSTS*8-1:0]           host_aw_len,
    input  logic [NUM_HOSTS*3-1:0]           host_aw_size,
    input  logic [NUM_HOSTS*2-1:0]           host_aw_burst,
    // host W
    input  logic [NUM_HOSTS-1:0]             host_w_valid,
    output logic [NUM_HOSTS-1:0]             host_w_ready,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]  host_w_data,
    input  logic [NUM_HOSTS*STRB_WIDTH-1:0]  host_w_strb,
    input  logic [NUM_HOSTS-1:0]             host_w_last,
    // host B
    output logic [NUM_HOSTS-1:0]             host_b_valid,
    input  logic [NUM_HOSTS-1:0]             host_b_ready,
    output logic [ID_WIDTH-1:0]              host_b_id,
    output logic [1:0]                       host_b_resp,
    // host R
    output logic [NUM_HOSTS-1:0]             host_r_valid,
    input  logic [NUM_HOSTS-1:0]             host_r_ready,
    output logic [DATA_WIDTH-1:0]            host_r_data,
    output logic [ID_WIDTH-1:0]              host_r_id,
    output logic [1:0]                       host_r_resp,
    output logic                             host_r_last,
    // device AR
    output logic                             device_ar_valid,
    input  logic                             device_ar_ready,
    output logic [ADDR_WIDTH-1:0]            device_ar_addr,
    output logic [DEV_ID_W-1:0]              device_ar_id,
    output logic [7:0]                       device_ar_len,
    output logic [2:0]                       device_ar_size,
    output logic [1:0]                       device_ar_burst,
    // device AW
    output logic                             device_aw_valid,
    input  logic                             device_aw_ready,
    output logic [ADDR_WIDTH-1:0]            device_aw_addr,
    output logic [DEV_ID_W-1:0]              device_aw_id,
    output logic [7:0]                       device_aw_len,
    output logic [2:0]                       device_aw_size,
    output logic [1:0]                       device_aw_burst,
    // device W
    output logic                             device_w_valid,
    input  logic                             device_w_ready,
    output logic [DATA_WIDTH-1:0]            device_w_data,
    output logic [STRB_WIDTH-1:0]            device_w_strb,
    output logic                             device_w_last,
    // device B
    input  logic                             device_b_valid,
    output logic                             device_b_ready,
    input  logic [DEV_ID_W-1:0]              device_b_id,
    input  logic [1:0]                       device_b_resp,
    // device R
    input  logic                             device_r_valid,
    output logic                             device_r_ready,
    input  logic [DATA_WIDTH-1:0]            device_r_data,
    input  logic [DEV_ID_W-1:0]              device_r_id,
    input  logic [1:0]                       device_r_resp,
    input  logic                             device_r_last
);

    localparam int c_ptr_w = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;

    // Round-robin pick: {found, index} of the first valid host at or after ptr.
    function automatic logic [HOST_IDX_W:0] rr_pick(input logic [NUM_HOSTS-1:0] valid,
                                                    input logic [HOST_IDX_W-1:0] ptr);
        logic [HOST_IDX_W:0] res;
        int                  k;
        res = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_HOSTS) k = k - NUM_HOSTS;
            if (!res[HOST_IDX_W] && valid[k]) res = {1'b1, k[HOST_IDX_W-1:0]};
        end
        return res;
    endfunction

    // Pointer advance past the winner, wrapping at NUM_HOSTS.
    function automatic logic [HOST_IDX_W-1:0] rr_next(input logic [HOST_IDX_W-1:0] w);
        return (int'(w) == NUM_HOSTS - 1) ? '0 : w + 1'b1;
    endfunction

    // ---------------- AR stage ----------------
    logic                  r_ar_valid;
    logic [HOST_IDX_W-1:0] r_ar_ptr;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [DEV_ID_W-1:0]   r_ar_id;
    logic [7:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic [HOST_IDX_W:0]   w_ar_pick;
    logic [HOST_IDX_W-1:0] w_ar_win;
    logic                  w_ar_free;
    logic                  w_ar_take;

    assign w_ar_pick = rr_pick(host_ar_valid, r_ar_ptr);
    assign w_ar_win  = w_ar_pick[HOST_IDX_W-1:0];
    assign w_ar_free = !r_ar_valid || device_ar_ready;
    assign w_ar_take = w_ar_free && w_ar_pick[HOST_IDX_W];

    // Grant is combinational; suppressed while reset is asserted.
    always_comb begin
        host_ar_ready = '0;
        if (w_ar_take && rst_ni) host_ar_ready[w_ar_win] = 1'b1;
    end

    // AR output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ar_valid <= 1'b0;
            r_ar_ptr   <= '0;
            r_ar_addr  <= '0;
            r_ar_id    <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
        end else if (w_ar_free) begin
            r_ar_valid <= w_ar_take;
            if (w_ar_take) begin
                r_ar_ptr   <= rr_next(w_ar_win);
                r_ar_addr  <= host_ar_addr[w_ar_win*ADDR_WIDTH +: ADDR_WIDTH];
                r_ar_id    <= {w_ar_win, host_ar_id[w_ar_win*ID_WIDTH +: ID_WIDTH]};
                r_ar_len   <= host_ar_len[w_ar_win*8 +: 8];
                r_ar_size  <= host_ar_size[w_ar_win*3 +: 3];
                r_ar_burst <= host_ar_burst[w_ar_win*2 +: 2];
            end
        end
    end

    assign device_ar_valid = r_ar_valid;
    assign device_ar_addr  = r_ar_addr;
    assign device_ar_id    = r_ar_id;
    assign device_ar_len   = r_ar_len;
    assign device_ar_size  = r_ar_size;
    assign device_ar_burst = r_ar_burst;

    // ---------------- AW stage ----------------
    logic                  r_aw_valid;
    logic [HOST_IDX_W-1:0] r_aw_ptr;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DEV_ID_W-1:0]   r_aw_id;
    logic [7:0]            r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic [HOST_IDX_W:0]   w_aw_pick;
    logic [HOST_IDX_W-1:0] w_aw_win;
    logic                  w_aw_free;
    logic                  w_aw_take;
    logic                  w_fifo_full;

    assign w_aw_pick = rr_pick(host_aw_valid, r_aw_ptr);
    assign w_aw_win  = w_aw_pick[HOST_IDX_W-1:0];
    assign w_aw_free = !r_aw_valid || device_aw_ready;
    // A full FIFO blocks the load even when a pop happens this cycle.
    assign w_aw_take = w_aw_free && w_aw_pick[HOST_IDX_W] && !w_fifo_full;

    // Grant is combinational; suppressed while reset is asserted.
    always_comb begin
        host_aw_ready = '0;
        if (w_aw_take && rst_ni) host_aw_ready[w_aw_win] = 1'b1;
    end

    // AW output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_valid <= 1'b0;
            r_aw_ptr   <= '0;
            r_aw_addr  <= '0;
            r_aw_id    <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
        end else if (w_aw_free) begin
            r_aw_valid <= w_aw_take;
            if (w_aw_take) begin
                r_aw_ptr   <= rr_next(w_aw_win);
                r_aw_addr  <= host_aw_addr[w_aw_win*ADDR_WIDTH +: ADDR_WIDTH];
                r_aw_id    <= {w_aw_win, host_aw_id[w_aw_win*ID_WIDTH +: ID_WIDTH]};
                r_aw_len   <= host_aw_len[w_aw_win*8 +: 8];
                r_aw_size  <= host_aw_size[w_aw_win*3 +: 3];
                r_aw_burst <= host_aw_burst[w_aw_win*2 +: 2];
            end
        end
    end

    assign device_aw_valid = r_aw_valid;
    assign device_aw_addr  = r_aw_addr;
    assign device_aw_id    = r_aw_id;
    assign device_aw_len   = r_aw_len;
    assign device_aw_size  = r_aw_size;
    assign device_aw_burst = r_aw_burst;

    // ---------------- W order FIFO ----------------
    logic [HOST_IDX_W-1:0] r_fifo_mem [WFIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_fifo_cnt;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [HOST_IDX_W-1:0] w_head;

    assign w_fifo_full  = (r_fifo_cnt == c_cnt_w'(WFIFO_DEPTH));
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_push       = w_aw_take;
    assign w_pop        = device_w_valid && device_w_ready && device_w_last;
    assign w_head       = r_fifo_mem[r_rd_ptr];

    // FIFO storage holds host indices only; contents are don't-care when empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= w_aw_win;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // W steering from the host at the FIFO head; no host is served when empty.
    always_comb begin
        host_w_ready   = '0;
        device_w_valid = 1'b0;
        device_w_data  = host_w_data[w_head*DATA_WIDTH +: DATA_WIDTH];
        device_w_strb  = host_w_strb[w_head*STRB_WIDTH +: STRB_WIDTH];
        device_w_last  = host_w_last[w_head];
        if (!w_fifo_empty) begin
            device_w_valid       = host_w_valid[w_head];
            host_w_ready[w_head] = device_w_ready;
        end
    end

    // ---------------- R/B return routing ----------------
    logic [HOST_IDX_W-1:0] w_r_idx;
    logic [HOST_IDX_W-1:0] w_b_idx;

    assign w_r_idx = device_r_id[DEV_ID_W-1 -: HOST_IDX_W];
    assign w_b_idx = device_b_id[DEV_ID_W-1 -: HOST_IDX_W];

    // Responses with an out-of-range prefix are accepted and dropped.
    always_comb begin
        host_r_valid   = '0;
        device_r_ready = 1'b1;
        host_b_valid   = '0;
        device_b_ready = 1'b1;
        if (int'(w_r_idx) < NUM_HOSTS) begin
            host_r_valid[w_r_idx] = device_r_valid;
            device_r_ready        = host_r_ready[w_r_idx];
        end
        if (int'(w_b_idx) < NUM_HOSTS) begin
            host_b_valid[w_b_idx] = device_b_valid;
            device_b_ready        = host_b_ready[w_b_idx];
        end
    end

    assign host_r_data = device_r_data;
    assign host_r_id   = device_r_id[ID_WIDTH-1:0];
    assign host_r_resp = device_r_resp;
    assign host_r_last = device_r_last;
    assign host_b_id   = device_b_id[ID_WIDTH-1:0];
    assign host_b_resp = device_b_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_mux.sv
`default_nettype none
//============================================================================
// Module      : tb_axi_mem_mux
// Description : Self-checking bench for axi_mem_mux (2 hosts, default sizes).
// Revision    : 1.0 - initial release
//============================================================================
module tb_axi_mem_mux;

    localparam int N   = 2;
    localparam int DW  = 128;
    localparam int AW  = 27;
    localparam int IW  = 8;
    localparam int SW  = DW / 8;
    localparam int HIW = 1;
    localparam int DIW = IW + HIW;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]    host_ar_valid, host_ar_ready;
    logic [N*AW-1:0] host_ar_addr;
    logic [N*IW-1:0] host_ar_id;
    logic [N*8-1:0]  host_ar_len;
    logic [N*3-1:0]  host_ar_size;
    logic [N*2-1:0]  host_ar_burst;
    logic [N-1:0]    host_aw_valid, host_aw_ready;
    logic [N*AW-1:0] host_aw_addr;
    logic [N*IW-1:0] host_aw_id;
    logic [N*8-1:0]  host_aw_len;
    logic [N*3-1:0]  host_aw_size;
    logic [N*2-1:0]  host_aw_burst;
    logic [N-1:0]    host_w_valid, host_w_ready;
    logic [N*DW-1:0] host_w_data;
    logic [N*SW-1:0] host_w_strb;
    logic [N-1:0]    host_w_last;
    logic [N-1:0]    host_b_valid, host_b_ready;
    logic [IW-1:0]   host_b_id;
    logic [1:0]      host_b_resp;
    logic [N-1:0]    host_r_valid, host_r_ready;
    logic [DW-1:0]   host_r_data;
    logic [IW-1:0]   host_r_id;
    logic [1:0]      host_r_resp;
    logic            host_r_last;
    logic            device_ar_valid, device_ar_ready;
    logic [AW-1:0]   device_ar_addr;
    logic [DIW-1:0]  device_ar_id;
    logic [7:0]      device_ar_len;
    logic [2:0]      device_ar_size;
    logic [1:0]      device_ar_burst;
    logic            device_aw_valid, device_aw_ready;
    logic [AW-1:0]   device_aw_addr;
    logic [DIW-1:0]  device_aw_id;
    logic [7:0]      device_aw_len;
    logic [2:0]      device_aw_size;
    logic [1:0]      device_aw_burst;
    logic            device_w_valid, device_w_ready;
    logic [DW-1:0]   device_w_data;
    logic [SW-1:0]   device_w_strb;
    logic            device_w_last;
    logic            device_b_valid, device_b_ready;
    logic [DIW-1:0]  device_b_id;
    logic [1:0]      device_b_resp;
    logic            device_r_valid, device_r_ready;
    logic [DW-1:0]   device_r_data;
    logic [DIW-1:0]  device_r_id;
    logic [1:0]      device_r_resp;
    logic            device_r_last;

    int errors = 0;
    int checks = 0;

    axi_mem_mux dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_ar_valid(host_ar_valid), .host_ar_ready(host_ar_ready), .host_ar_addr(host_ar_addr),
        .host_ar_id(host_ar_id), .host_ar_len(host_ar_len), .host_ar_size(host_ar_size),
        .host_ar_burst(host_ar_burst),
        .host_aw_valid(host_aw_valid), .host_aw_ready(host_aw_ready), .host_aw_addr(host_aw_addr),
        .host_aw_id(host_aw_id), .host_aw_len(host_aw_len), .host_aw_size(host_aw_size),
        .host_aw_burst(host_aw_burst),
        .host_w_valid(host_w_valid), .host_w_ready(host_w_ready), .host_w_data(host_w_data),
        .host_w_strb(host_w_strb), .host_w_last(host_w_last),
        .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_id(host_b_id),
        .host_b_resp(host_b_resp),
        .host_r_valid(host_r_valid), .host_r_ready(host_r_ready), .host_r_data(host_r_data),
        .host_r_id(host_r_id), .host_r_resp(host_r_resp), .host_r_last(host_r_last),
        .device_ar_valid(device_ar_valid), .device_ar_ready(device_ar_ready),
        .device_ar_addr(device_ar_addr), .device_ar_id(device_ar_id), .device_ar_len(device_ar_len),
        .device_ar_size(device_ar_size), .device_ar_burst(device_ar_burst),
        .device_aw_valid(device_aw_valid), .device_aw_ready(device_aw_ready),
        .device_aw_addr(device_aw_addr), .device_aw_id(device_aw_id), .device_aw_len(device_aw_len),
        .device_aw_size(device_aw_size), .device_aw_burst(device_aw_burst),
        .device_w_valid(device_w_valid), .device_w_ready(device_w_ready),
        .device_w_data(device_w_data), .device_w_strb(device_w_strb), .device_w_last(device_w_last),
        .device_b_valid(device_b_valid), .device_b_ready(device_b_ready),
        .device_b_id(device_b_id), .device_b_resp(device_b_resp),
        .device_r_valid(device_r_valid), .device_r_ready(device_r_ready),
        .device_r_data(device_r_data), .device_r_id(device_r_id), .device_r_resp(device_r_resp),
        .device_r_last(device_r_last)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        host_ar_valid = '0; host_ar_addr = '0; host_ar_id = '0; host_ar_len = '0;
        host_ar_size = '0; host_ar_burst = '0;
        host_aw_valid = '0; host_aw_addr = '0; host_aw_id = '0; host_aw_len = '0;
        host_aw_size = '0; host_aw_burst = '0;
        host_w_valid = '0; host_w_data = '0; host_w_strb = '0; host_w_last = '0;
        host_b_ready = '0; host_r_ready = '0;
        device_ar_ready = 1'b0; device_aw_ready = 1'b0; device_w_ready = 1'b0;
        device_b_valid = 1'b0; device_b_id = '0; device_b_resp = '0;
        device_r_valid = 1'b0; device_r_data = '0; device_r_id = '0; device_r_resp = '0;
        device_r_last = 1'b0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic set_ar(input int h, input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [7:0] len);
        host_ar_addr[h*AW +: AW] = a;
        host_ar_id[h*IW +: IW]   = id;
        host_ar_len[h*8 +: 8]    = len;
        host_ar_size[h*3 +: 3]   = 3'd4;
        host_ar_burst[h*2 +: 2]  = 2'b01;
    endtask

    task automatic set_aw(input int h, input logic [AW-1:0] a, input logic [IW-1:0] id,
                          input logic [7:0] len);
        host_aw_addr[h*AW +: AW] = a;
        host_aw_id[h*IW +: IW]   = id;
        host_aw_len[h*8 +: 8]    = len;
        host_aw_size[h*3 +: 3]   = 3'd4;
        host_aw_burst[h*2 +: 2]  = 2'b01;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        host_ar_valid = 2'b11; host_aw_valid = 2'b11; host_w_valid = 2'b11;
        device_ar_ready = 1'b1; device_aw_ready = 1'b1; device_w_ready = 1'b1;
        tick();
        checks++; if (host_ar_ready !== 2'b00) begin errors++; $display("FAIL rst_ar_ready: got %b want 00", host_ar_ready); end
        checks++; if (host_aw_ready !== 2'b00) begin errors++; $display("FAIL rst_aw_ready: got %b want 00", host_aw_ready); end
        checks++; if (host_w_ready !== 2'b00) begin errors++; $display("FAIL rst_w_ready: got %b want 00", host_w_ready); end
        checks++; if (device_ar_valid !== 1'b0) begin errors++; $display("FAIL rst_dev_ar_valid: got %b want 0", device_ar_valid); end
        checks++; if (device_aw_valid !== 1'b0) begin errors++; $display("FAIL rst_dev_aw_valid: got %b want 0", device_aw_valid); end
        checks++; if (device_w_valid !== 1'b0) begin errors++; $display("FAIL rst_dev_w_valid: got %b want 0", device_w_valid); end
        idle_inputs();
        rst_ni = 1'b1;
    endtask

    task automatic test_ar_rr();
        apply_reset();
        set_ar(0, 27'h123450, 8'h11, 8'd0);
        set_ar(1, 27'h0abcd0, 8'h22, 8'd1);
        host_ar_valid = 2'b11;
        #1;
        checks++; if (host_ar_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b want 01", host_ar_ready); end
        tick();
        host_ar_valid = 2'b10;
        checks++; if (device_ar_valid !== 1'b1 || device_ar_id !== {1'b0, 8'h11} || device_ar_addr !== 27'h123450)
            begin errors++; $display("FAIL rr_first_out: got v=%b id=%h addr=%h want 1 011 123450", device_ar_valid, device_ar_id, device_ar_addr); end
        #1;
        checks++; if (host_ar_ready !== 2'b00) begin errors++; $display("FAIL rr_full_no_grant: got %b want 00", host_ar_ready); end
        device_ar_ready = 1'b1;
        #1;
        checks++; if (host_ar_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b want 10", host_ar_ready); end
        tick();
        host_ar_valid = 2'b00;
        checks++; if (device_ar_id !== {1'b1, 8'h22} || device_ar_addr !== 27'h0abcd0 || device_ar_len !== 8'd1)
            begin errors++; $display("FAIL rr_second_out: got id=%h addr=%h len=%0d want 122 0abcd0 1", device_ar_id, device_ar_addr, device_ar_len); end
        tick();
        checks++; if (device_ar_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", device_ar_valid); end
    endtask

    task automatic test_ar_stall();
        apply_reset();
        set_ar(0, 27'h7654321, 8'h33, 8'd7);
        host_ar_valid = 2'b01;
        tick();
        set_ar(1, 27'h0000040, 8'h44, 8'd2);
        host_ar_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (device_ar_valid !== 1'b1 || device_ar_id !== {1'b0, 8'h33} || device_ar_addr !== 27'h7654321 || device_ar_len !== 8'd7)
                begin errors++; $display("FAIL stall_hold[%0d]: got v=%b id=%h addr=%h len=%0d", i, device_ar_valid, device_ar_id, device_ar_addr, device_ar_len); end
            checks++; if (host_ar_ready !== 2'b00) begin errors++; $display("FAIL stall_no_grant[%0d]: got %b want 00", i, host_ar_ready); end
            tick();
        end
        device_ar_ready = 1'b1;
        #1;
        checks++; if (host_ar_ready !== 2'b10) begin errors++; $display("FAIL stall_release_grant: got %b want 10", host_ar_ready); end
        tick();
        host_ar_valid = 2'b00;
        checks++; if (device_ar_id !== {1'b1, 8'h44}) begin errors++; $display("FAIL stall_next_out: got %h want 144", device_ar_id); end
        tick();
        checks++; if (device_ar_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", device_ar_valid); end
    endtask

    task automatic test_w_order();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1 [4];
        apply_reset();
        device_aw_ready = 1'b1;
        device_w_ready  = 1'b1;
        d0 = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < 4; b++) d1[b] = {$urandom, $urandom, $urandom, $urandom};
        host_w_data[0 +: DW] = d0;
        host_w_strb = '1;
        host_w_last[0] = 1'b1;
        host_w_valid = 2'b01;
        set_aw(1, 27'h100, 8'h51, 8'd3);
        host_aw_valid = 2'b10;
        #1;
        checks++; if (host_aw_ready !== 2'b10) begin errors++; $display("FAIL worder_aw1_grant: got %b want 10", host_aw_ready); end
        checks++; if (host_w_ready !== 2'b00 || device_w_valid !== 1'b0) begin errors++; $display("FAIL worder_empty: got ready=%b v=%b want 00 0", host_w_ready, device_w_valid); end
        tick();
        set_aw(0, 27'h200, 8'h50, 8'd0);
        host_aw_valid = 2'b01;
        #1;
        checks++; if (host_aw_ready !== 2'b01) begin errors++; $display("FAIL worder_aw0_grant: got %b want 01", host_aw_ready); end
        checks++; if (device_aw_id !== {1'b1, 8'h51} || device_aw_len !== 8'd3) begin errors++; $display("FAIL worder_aw1_out: got id=%h len=%0d want 151 3", device_aw_id, device_aw_len); end
        checks++; if (host_w_ready !== 2'b10 || device_w_valid !== 1'b0) begin errors++; $display("FAIL worder_host0_stall: got ready=%b v=%b want 10 0", host_w_ready, device_w_valid); end
        tick();
        host_aw_valid = 2'b00;
        for (int b = 0; b < 4; b++) begin
            host_w_data[DW +: DW] = d1[b];
            host_w_last[1] = (b == 3);
            host_w_valid = 2'b11;
            #1;
            checks++; if (device_w_valid !== 1'b1 || device_w_data !== d1[b] || device_w_last !== (b == 3) || host_w_ready !== 2'b10)
                begin errors++; $display("FAIL worder_h1_beat[%0d]: got v=%b last=%b ready=%b data=%h", b, device_w_valid, device_w_last, host_w_ready, device_w_data); end
            tick();
        end
        host_w_valid = 2'b01;
        #1;
        checks++; if (device_w_valid !== 1'b1 || device_w_data !== d0 || device_w_last !== 1'b1 || host_w_ready !== 2'b01)
            begin errors++; $display("FAIL worder_h0_beat: got v=%b last=%b ready=%b data=%h", device_w_valid, device_w_last, host_w_ready, device_w_data); end
        tick();
        checks++; if (device_w_valid !== 1'b0 || host_w_ready !== 2'b00) begin errors++; $display("FAIL worder_done: got v=%b ready=%b want 0 00", device_w_valid, host_w_ready); end
        host_w_valid = 2'b00;
    endtask

    task automatic test_wfifo_full();
        apply_reset();
        device_aw_ready = 1'b1;
        device_w_ready  = 1'b1;
        host_aw_valid   = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_aw(0, AW'(i * 64), IW'(8'h60 + i), 8'd0);
            #1;
            checks++; if (host_aw_ready !== 2'b01) begin errors++; $display("FAIL full_fill[%0d]: got %b want 01", i, host_aw_ready); end
            tick();
        end
        set_aw(0, 27'h4000, 8'h64, 8'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (host_aw_ready !== 2'b00) begin errors++; $display("FAIL full_block[%0d]: got %b want 00", i, host_aw_ready); end
            tick();
        end
        host_w_valid   = 2'b01;
        host_w_last[0] = 1'b1;
        host_w_data[0 +: DW] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++; if (host_aw_ready !== 2'b00 || device_w_valid !== 1'b1) begin errors++; $display("FAIL full_pop_same_cycle: got aw_ready=%b w_valid=%b want 00 1", host_aw_ready, device_w_valid); end
        tick();
        host_w_valid = 2'b00;
        #1;
        checks++; if (host_aw_ready !== 2'b01) begin errors++; $display("FAIL full_after_pop: got %b want 01", host_aw_ready); end
        tick();
        host_aw_valid = 2'b00;
        checks++; if (device_aw_valid !== 1'b1 || device_aw_id !== {1'b0, 8'h64}) begin errors++; $display("FAIL full_fifth_out: got v=%b id=%h want 1 064", device_aw_valid, device_aw_id); end
    endtask

    task automatic test_r_route();
        logic [DW-1:0] d;
        apply_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        device_r_valid = 1'b1;
        device_r_id    = {1'b1, 8'h2A};
        device_r_data  = d;
        device_r_resp  = 2'b01;
        device_r_last  = 1'b1;
        host_r_ready   = 2'b00;
        #1;
        checks++; if (host_r_valid !== 2'b10 || host_r_id !== 8'h2A || device_r_ready !== 1'b0)
            begin errors++; $display("FAIL r_route_wait: got v=%b id=%h dready=%b want 10 2a 0", host_r_valid, host_r_id, device_r_ready); end
        checks++; if (host_r_data !== d || host_r_resp !== 2'b01 || host_r_last !== 1'b1)
            begin errors++; $display("FAIL r_route_fields: got data=%h resp=%b last=%b", host_r_data, host_r_resp, host_r_last); end
        host_r_ready = 2'b10;
        #1;
        checks++; if (device_r_ready !== 1'b1) begin errors++; $display("FAIL r_route_accept: got %b want 1", device_r_ready); end
        tick();
        device_r_valid = 1'b0;
    endtask

    // Random R/B routing against the prefix-decode rule.
    task automatic test_random_route();
        int idx;
        logic [N-1:0] exp_v;
        logic         exp_rdy;
        for (int i = 0; i < 60; i++) begin
            device_r_id    = DIW'($urandom_range(0, (1 << DIW) - 1));
            device_r_valid = 1'($urandom_range(0, 1));
            device_r_data  = {$urandom, $urandom, $urandom, $urandom};
            host_r_ready   = N'($urandom_range(0, 3));
            #1;
            idx     = int'(device_r_id) / (1 << IW);
            exp_v   = (idx < N && device_r_valid) ? N'(1 << idx) : '0;
            exp_rdy = (idx < N) ? host_r_ready[idx] : 1'b1;
            checks++; if (host_r_valid !== exp_v || device_r_ready !== exp_rdy || host_r_id !== IW'(int'(device_r_id) % (1 << IW)) || host_r_data !== device_r_data)
                begin errors++; $display("FAIL rnd_r_route[%0d]: id=%h got v=%b rdy=%b want v=%b rdy=%b", i, device_r_id, host_r_valid, device_r_ready, exp_v, exp_rdy); end
            device_b_id    = DIW'($urandom_range(0, (1 << DIW) - 1));
            device_b_valid = 1'($urandom_range(0, 1));
            device_b_resp  = 2'($urandom_range(0, 3));
            host_b_ready   = N'($urandom_range(0, 3));
            #1;
            idx     = int'(device_b_id) / (1 << IW);
            exp_v   = (idx < N && device_b_valid) ? N'(1 << idx) : '0;
            exp_rdy = (idx < N) ? host_b_ready[idx] : 1'b1;
            checks++; if (host_b_valid !== exp_v || device_b_ready !== exp_rdy || host_b_id !== IW'(int'(device_b_id) % (1 << IW)) || host_b_resp !== device_b_resp)
                begin errors++; $display("FAIL rnd_b_route[%0d]: id=%h got v=%b rdy=%b want v=%b rdy=%b", i, device_b_id, host_b_valid, device_b_ready, exp_v, exp_rdy); end
            tick();
        end
        device_r_valid = 1'b0;
        device_b_valid = 1'b0;
    endtask

    // Random AR traffic against a one-slot round-robin reference model.
    task automatic test_random_ar();
        int            ptr;
        int            win;
        bit            free;
        bit            m_valid;
        logic [DIW-1:0] m_id;
        logic [AW-1:0]  m_addr;
        logic [N-1:0]   exp_rdy;
        apply_reset();
        ptr = 0;
        m_valid = 1'b0;
        m_id = '0;
        m_addr = '0;
        for (int c = 0; c < 150; c++) begin
            host_ar_valid = N'($urandom_range(0, 3));
            for (int h = 0; h < N; h++) set_ar(h, AW'($urandom), IW'($urandom), 8'($urandom));
            device_ar_ready = 1'($urandom_range(0, 1));
            #1;
            free = !m_valid || device_ar_ready;
            win = -1;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && host_ar_valid[(ptr + k) % N]) win = (ptr + k) % N;
                end
            end
            exp_rdy = (win >= 0) ? N'(1 << win) : '0;
            checks++; if (host_ar_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ar_grant[%0d]: got %b want %b", c, host_ar_ready, exp_rdy); end
            if (free) begin
                m_valid = (win >= 0);
                if (win >= 0) begin
                    m_id   = {HIW'(win), host_ar_id[win*IW +: IW]};
                    m_addr = host_ar_addr[win*AW +: AW];
                    ptr    = (win + 1) % N;
                end
            end
            tick();
            checks++; if (device_ar_valid !== m_valid) begin errors++; $display("FAIL rnd_ar_valid[%0d]: got %b want %b", c, device_ar_valid, m_valid); end
            if (m_valid) begin
                checks++; if (device_ar_id !== m_id || device_ar_addr !== m_addr)
                    begin errors++; $display("FAIL rnd_ar_out[%0d]: got id=%h addr=%h want id=%h addr=%h", c, device_ar_id, device_ar_addr, m_id, m_addr); end
            end
        end
        host_ar_valid = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        device_aw_ready = 1'b1;
        device_w_ready  = 1'b1;
        set_ar(0, 27'h80, 8'h70, 8'd0);
        set_aw(0, 27'h90, 8'h71, 8'd3);
        host_ar_valid = 2'b01;
        host_aw_valid = 2'b01;
        tick();
        host_ar_valid = 2'b00;
        host_aw_valid = 2'b00;
        host_w_valid  = 2'b01;
        host_w_last   = 2'b00;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        host_ar_valid = 2'b11; host_aw_valid = 2'b11; host_w_valid = 2'b11;
        device_ar_ready = 1'b1;
        #1;
        checks++; if (device_ar_valid !== 1'b0 || device_aw_valid !== 1'b0) begin errors++; $display("FAIL midrst_dev_valid: got ar=%b aw=%b want 0 0", device_ar_valid, device_aw_valid); end
        checks++; if (host_ar_ready !== 2'b00 || host_aw_ready !== 2'b00 || host_w_ready !== 2'b00)
            begin errors++; $display("FAIL midrst_readies: got ar=%b aw=%b w=%b want 00", host_ar_ready, host_aw_ready, host_w_ready); end
        checks++; if (device_w_valid !== 1'b0) begin errors++; $display("FAIL midrst_w_valid: got %b want 0", device_w_valid); end
        tick();
        rst_ni = 1'b1;
        #1;
        checks++; if (device_w_valid !== 1'b0 || host_w_ready !== 2'b00) begin errors++; $display("FAIL midrst_fifo_empty: got v=%b ready=%b want 0 00", device_w_valid, host_w_ready); end
        checks++; if (host_ar_ready !== 2'b01 || host_aw_ready !== 2'b01)
            begin errors++; $display("FAIL midrst_ptr_restart: got ar=%b aw=%b want 01 01", host_ar_ready, host_aw_ready); end
        tick();
        idle_inputs();
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        test_reset();
        test_ar_rr();
        test_ar_stall();
        test_w_order();
        test_wfifo_full();
        test_r_route();
        test_random_route();
        test_random_ar();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
